regbank_rr_arbiter: RTL and testbench

Shared write-port controller for a small register bank built from reset-clearable D-type storage. Up to NUM_REQ requesters contend for the single write port. The block grants one requester per cycle using round-robin with bounded bursts, commits the granted write into the bank, and provides one asynchronous read port. It sits between requesting datapath blocks and the register storage, and serializes all bank writes.

---
 rtl/regbank_pkg.sv | 23 ++
 rtl/regbank_rr_arbiter_rr_pick.sv | 32 +++
 rtl/regbank_rr_arbiter.sv | 117 +++++++++++
 tb/tb_regbank_rr_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared types and defaults for the register-bank write-port arbiter.
// Holds the FSM encoding, default sizing and an index-width helper.
package regbank_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } fsm_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_MAX_BURST = 4;

    // Bits needed to index v items; never below 1 so vectors stay legal.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/regbank_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest set request at or above start_i,
// wrapping to the lowest set request overall.
module rr_pick
    import regbank_pkg::*;
#(
    parameter int N = DEF_NUM_REQ
) (
    input  logic [N-1:0]          req_i,
    input  logic [clog2(N)-1:0]   start_i,
    output logic [N-1:0]          onehot_o,
    output logic                  found_o
);

    localparam int IW = clog2(N);

    logic [N-1:0] ge_mask;
    logic [N-1:0] hi_req;
    logic [N-1:0] sel_req;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign ge_mask[gi] = (IW'(gi) >= start_i);
        end
    endgenerate

    // Requests at/after start win; otherwise fall back to the wrapped set.
    assign hi_req   = req_i & ge_mask;
    assign sel_req  = (|hi_req) ? hi_req : req_i;
    assign onehot_o = sel_req & (~sel_req + N'(1));
    assign found_o  = |req_i;

endmodule

// File: rtl/regbank_rr_arbiter.sv
// Round-robin, burst-limited write-port arbiter in front of a reset-clearable
// register bank with one combinational read port.
module regbank_rr_arbiter
    import regbank_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*clog2(DEPTH)-1:0]   wr_addr,
    input  logic [NUM_REQ*WIDTH-1:0]          wr_data,
    output logic [NUM_REQ-1:0]                gnt,
    input  logic [clog2(DEPTH)-1:0]           rd_addr,
    output logic [WIDTH-1:0]                  rd_data
);

    localparam int AW = clog2(DEPTH);
    localparam int IW = clog2(NUM_REQ);
    localparam int CW = clog2(MAX_BURST + 1);

    fsm_e             fsm_q, fsm_d;
    logic [IW-1:0]    last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] bank_q [DEPTH];

    logic [IW-1:0]      start_idx;
    logic [IW-1:0]      gnt_idx;
    logic [NUM_REQ-1:0] last_oh;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_found;
    logic               cont_sel;
    logic               wr_en;
    logic [AW-1:0]      wr_addr_sel;
    logic [WIDTH-1:0]   wr_data_sel;

    assign start_idx = (last_q == IW'(NUM_REQ - 1)) ? '0 : last_q + IW'(1);

    rr_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .req_i    (req),
        .start_i  (start_idx),
        .onehot_o (pick_oh),
        .found_o  (pick_found)
    );

    assign last_oh  = NUM_REQ'(1) << last_q;
    assign cont_sel = (fsm_q == ST_OWN) && req[last_q] && (cnt_q < CW'(MAX_BURST));

    // Reset gates the grant so an in-flight request is abandoned immediately.
    always_comb begin
        gnt = '0;
        if (!reset)
            gnt = '0;
        else if (cont_sel)
            gnt = last_oh;
        else if (pick_found)
            gnt = pick_oh;
    end

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k])
                gnt_idx = IW'(k);
        end
    end

    assign wr_en       = |gnt;
    assign wr_addr_sel = wr_addr[gnt_idx*AW +: AW];
    assign wr_data_sel = wr_data[gnt_idx*WIDTH +: WIDTH];

    // A rotate that lands back on last restarts the tenure at 1.
    always_comb begin
        fsm_d  = fsm_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        if (wr_en) begin
            fsm_d  = ST_OWN;
            last_d = gnt_idx;
            cnt_d  = cont_sel ? cnt_q + CW'(1) : CW'(1);
        end else begin
            fsm_d = ST_IDLE;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q  <= ST_IDLE;
            last_q <= IW'(NUM_REQ - 1);
            cnt_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bank
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    bank_q[gi] <= '0;
                else if (wr_en && (wr_addr_sel == AW'(gi)))
                    bank_q[gi] <= wr_data_sel;
            end
        end
    endgenerate

    assign rd_data = bank_q[rd_addr];

endmodule

// File: tb/tb_regbank_rr_arbiter.sv
// Directed bench for regbank_rr_arbiter: two instances (burst 1 and burst 4)
// share stimulus and are checked every cycle against a behavioural model.
module tb_regbank_rr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  rd_addr;
    logic [3:0]  gnt_b1, gnt_b4;
    logic [7:0]  rd_b1, rd_b4;

    int tests = 0;
    int fails = 0;

    regbank_rr_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(8), .MAX_BURST(1)) dut_b1 (
        .clk(clk), .reset(reset), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
        .gnt(gnt_b1), .rd_addr(rd_addr), .rd_data(rd_b1)
    );

    regbank_rr_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(8), .MAX_BURST(4)) dut_b4 (
        .clk(clk), .reset(reset), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
        .gnt(gnt_b4), .rd_addr(rd_addr), .rd_data(rd_b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0: burst 1, index 1: burst 4)
    int         m_last [2];
    int         m_cnt  [2];
    bit         m_own  [2];
    logic [7:0] m_bank [2][8];

    function automatic int mb(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic bit model_cont(input int k);
        return m_own[k] && req[m_last[k]] && (m_cnt[k] < mb(k));
    endfunction

    function automatic int model_pick(input int k);
        int i;
        if (model_cont(k)) return m_last[k];
        for (int s = 1; s <= 4; s++) begin
            i = (m_last[k] + s) % 4;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_gnt(input int k);
        int p;
        p = model_pick(k);
        return (p < 0) ? 4'b0000 : (4'b0001 << p);
    endfunction

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            for (int k = 0; k < 2; k++) begin
                int p;
                p = model_pick(k);
                if (p >= 0) begin
                    m_bank[k][wr_addr[p*3 +: 3]] <= wr_data[p*8 +: 8];
                    m_cnt[k]  <= model_cont(k) ? m_cnt[k] + 1 : 1;
                    m_last[k] <= p;
                    m_own[k]  <= 1'b1;
                    if (k == 1)
                        $display("[TB] t=%0t burst4 grant req%0d addr %0d data %02h",
                                 $time, p, wr_addr[p*3 +: 3], wr_data[p*8 +: 8]);
                end else begin
                    m_own[k] <= 1'b0;
                    m_cnt[k] <= 0;
                end
            end
        end
    end

    // Per-cycle compare at the falling edge; reset forces zero expectations.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            chk("cyc_gnt_b1_rst", gnt_b1, 4'b0000);
            chk("cyc_gnt_b4_rst", gnt_b4, 4'b0000);
            chk("cyc_rd_b1_rst", rd_b1, 8'h00);
            chk("cyc_rd_b4_rst", rd_b4, 8'h00);
            for (int k = 0; k < 2; k++) begin
                m_last[k] <= 3;
                m_cnt[k]  <= 0;
                m_own[k]  <= 1'b0;
                for (int a = 0; a < 8; a++) m_bank[k][a] <= 8'h00;
            end
        end else begin
            chk("cyc_gnt_b1", gnt_b1, model_gnt(0));
            chk("cyc_gnt_b4", gnt_b4, model_gnt(1));
            chk("cyc_rd_b1", rd_b1, m_bank[0][rd_addr]);
            chk("cyc_rd_b4", rd_b4, m_bank[1][rd_addr]);
        end
    end

    // ---------------- directed stimulus with literal expectations
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [2:0] a, input logic [7:0] d);
        wr_addr[i*3 +: 3] = a;
        wr_data[i*8 +: 8] = d;
    endtask

    logic [3:0] fair_seq  [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] burst_seq [12] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                   4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                   4'b0001, 4'b0001, 4'b0001, 4'b0001};
    logic [7:0] lone_bank [8]  = '{8'h48, 8'h49, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};

    initial begin
        reset   = 1'b0;
        req     = 4'b1111;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        for (int i = 0; i < 4; i++) set_slot(i, 3'(i), 8'h10 + 8'(i));

        // Reset holds grants off and the bank clear.
        for (int a = 0; a < 8; a++) begin
            next_cycle();
            rd_addr = 3'(a);
            #1;
            chk("rst_gnt_b1", gnt_b1, 4'b0000);
            chk("rst_gnt_b4", gnt_b4, 4'b0000);
            chk("rst_rd_b4", rd_b4, 8'h00);
        end

        // Fairness with burst 1; first grant after release goes to requester 0.
        next_cycle();
        reset = 1'b1;
        #1;
        chk("release_gnt_b4", gnt_b4, 4'b0001);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                next_cycle();
                #1;
            end
            chk("fair_gnt_b1", gnt_b1, fair_seq[c]);
        end
        next_cycle();
        req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 3'(i);
            #1;
            chk("fair_bank_b1", rd_b1, 8'h10 + 8'(i));
            next_cycle();
        end

        // Burst limit: two requesters alternate in tenures of 4 (and of 1).
        req = 4'b0011;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("burst_gnt_b4", gnt_b4, burst_seq[c]);
            chk("burst_gnt_b1", gnt_b1, (c % 2 == 0) ? 4'b0010 : 4'b0001);
            next_cycle();
        end
        req = 4'b0000;
        next_cycle();

        // Lone requester keeps the port across its own burst limit.
        req = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            set_slot(2, 3'(k % 8), 8'h40 + 8'(k));
            #1;
            chk("lone_gnt_b4", gnt_b4, 4'b0100);
            chk("lone_gnt_b1", gnt_b1, 4'b0100);
            next_cycle();
        end
        req = 4'b0000;
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            chk("lone_bank_b4", rd_b4, lone_bank[a]);
            next_cycle();
        end

        // Write then read: old value during grant, new value after the edge.
        req = 4'b0010;
        set_slot(1, 3'd3, 8'hA5);
        rd_addr = 3'd3;
        #1;
        chk("wr_gnt_b4", gnt_b4, 4'b0010);
        chk("wr_old_b4", rd_b4, 8'h43);
        next_cycle();
        req = 4'b0000;
        #1;
        chk("wr_new_b4", rd_b4, 8'hA5);
        chk("wr_new_b1", rd_b1, 8'hA5);
        next_cycle();

        // Reset mid-grant: grant drops at once and the write is abandoned.
        req = 4'b0010;
        set_slot(1, 3'd6, 8'h5A);
        rd_addr = 3'd6;
        #1;
        chk("midrst_gnt_pre", gnt_b4, 4'b0010);
        chk("midrst_rd_pre", rd_b4, 8'h46);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_gnt_b4", gnt_b4, 4'b0000);
        chk("midrst_gnt_b1", gnt_b1, 4'b0000);
        chk("midrst_rd_b4", rd_b4, 8'h00);
        next_cycle();
        next_cycle();
        req   = 4'b0000;
        reset = 1'b1;
        #1;
        chk("postrst_rd_b4", rd_b4, 8'h00);
        chk("postrst_rd_b1", rd_b1, 8'h00);
        next_cycle();
        req = 4'b1111;
        #1;
        chk("postrst_gnt_b4", gnt_b4, 4'b0001);
        chk("postrst_gnt_b1", gnt_b1, 4'b0001);
        next_cycle();
        next_cycle();
        req = 4'b0000;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        tests++;
        fails++;
        $display("FAIL watchdog: stimulus did not complete by %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
